onehot_dispatcher: RTL
======================

# onehot_dispatcher

Decoding counterpart of the 4-to-2 priority encoder. Accepts an encoded line index with a valid/ready handshake and drives the matching one-hot request line. Holds that line until the addressed consumer acknowledges it, or until a timeout expires. Sits downstream of the priority encoder and turns its `{out, valid}` pair back into one-hot per-line requests, with flow control and error reporting.

## Interface
- `IDX_W`, default 2: index width; number of lines N = 2**IDX_W (4 by default).
- `TIMEOUT`, default 15: maximum cycles a request line stays asserted without ack; legal range 1..255.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_idx`  in  IDX_W  encoded line index (encoder `out`).
- `in_valid`  in  1  index valid (encoder `valid`).
- `in_ready`  out  1  block can accept an index this cycle.
- `out_onehot`  out  N  one-hot request; bit `in_idx` set while a request is active.
- `ack`  in  N  per-line acknowledge from consumers.
- `busy`  out  1  a request is active.
- `done`  out  1  one-cycle pulse: request acknowledged.
- `timeout_err`  out  1  one-cycle pulse: request expired without ack.
- `done_count`  out  8  number of acknowledged requests; saturates at 255.

## Operation
- FSM states: IDLE and DRIVE.
- **IDLE**
  - `in_ready`=1, `busy`=0, `out_onehot`=0.
  - On an edge with `in_valid`=1: capture `in_idx`, clear the cycle counter, go to DRIVE.
- **DRIVE**
  - `in_ready`=0, `busy`=1, `out_onehot` = 1 << captured index. Exactly one bit is set.
  - `in_idx` and `in_valid` are ignored in this state.
  - On each edge, check `ack[idx]` first:
    - `ack[idx]`=1: go to IDLE, pulse `done`, increment `done_count` (saturating).
    - Otherwise, if counter == TIMEOUT-1: go to IDLE, pulse `timeout_err`.
    - Otherwise: counter += 1.
  - `ack` bits other than `ack[idx]` are ignored.
- Simultaneous events:
  - Ack on the final timeout cycle counts as an ack: `done`=1, `timeout_err`=0.
  - `done` and `timeout_err` are never high together.
- Counter width is 8 bits. It never exceeds TIMEOUT-1 and never wraps.
- `done_count` holds at 255 once it reaches 255. It is cleared only by reset.
- Reset mid-DRIVE: the request line drops, no `done` or `timeout_err` pulse is issued, and the captured index is discarded.

## Timing
- Reset values (all outputs): `in_ready`=1, `busy`=0, `out_onehot`=0, `done`=0, `timeout_err`=0, `done_count`=0. FSM returns to IDLE.
- Handshake:
  - Transfer occurs on edge k when `in_valid`=1 and `in_ready`=1.
  - `out_onehot` and `busy` are asserted from cycle k+1.
  - `in_ready` is a registered function of state; it does not depend combinationally on `in_valid`.
- Ack latency:
  - `ack[idx]` sampled high at edge m → from cycle m+1, `out_onehot`=0, `busy`=0, `in_ready`=1, and `done`=1 for that single cycle.
  - Minimum request duration is 1 cycle (ack already high in cycle k+1).
- Timeout:
  - With no ack, `out_onehot` is high for exactly TIMEOUT cycles (k+1 .. k+TIMEOUT).
  - `timeout_err`=1 in cycle k+TIMEOUT+1.
- Back-to-back: the next transfer can occur on edge m+1, giving one idle cycle between requests. Throughput is at most one request per 2 cycles.
- `done_count` updates in the same cycle that `done` goes high.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs → all outputs at their reset values; release → `in_ready`=1.
- Basic decode: for each `in_idx` in 0..3, one-cycle `in_valid`, then `ack` = matching bit 2 cycles later:
  - `out_onehot` sequence 0001, 0010, 0100, 1000.
  - `done` pulses 4 times, `done_count`=4.
- Wrong-line ack and timeout: `in_idx`=2 with `ack`=4'b0001 held → `out_onehot`=0100 for exactly 15 cycles, then `timeout_err`=1 for 1 cycle; `done_count` unchanged.
- Ack on the boundary: `in_idx`=1, `ack[1]` on the 15th asserted cycle → `done`=1, `timeout_err`=0.
- Backpressure: `in_valid` held high with `in_idx` changing 3→0 while in DRIVE → index stays 3 until ack; the next capture takes `in_idx` at the first IDLE edge.
- Reset mid-operation and saturation:
  - `rst_n`=0 during DRIVE → `out_onehot`=0 next cycle, no pulses.
  - 260 acked requests → `done_count`=255.

Source files
------------

// File: rtl/onehot_dispatcher.sv
// onehot_dispatcher
// Turns an encoded line index into a held one-hot request line.
// The line stays up until its consumer acknowledges it or a timeout expires.
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_idx       encoded line index
//   in_valid     index valid
//   in_ready     index can be accepted this cycle (registered)
//   out_onehot   one-hot request line, 1 << captured index while active
//   ack          per-line acknowledge; only the active line's bit is used
//   busy         a request is active
//   done         one-cycle pulse: request acknowledged
//   timeout_err  one-cycle pulse: request expired without ack
//   done_count   saturating count of acknowledged requests
module onehot_dispatcher #(
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [(1<<IDX_W)-1:0] out_onehot,
  input  logic [(1<<IDX_W)-1:0] ack,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [7:0]            done_count
);

  localparam int unsigned N = 1 << IDX_W;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_onehot  <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      done_count  <= '0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= DRIVE;
            idx        <= in_idx;
            cnt        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            out_onehot <= ONE << in_idx;
          end
        end
        DRIVE: begin
          // Ack wins over an expiry on the same edge.
          if (ack[idx]) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_onehot <= '0;
            done       <= 1'b1;
            if (done_count != 8'hFF) done_count <= done_count + 8'd1;
          end else if (cnt == LAST) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            out_onehot  <= '0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready   <= 1'b1;
          busy       <= 1'b0;
          out_onehot <= '0;
        end
      endcase
    end
  end

endmodule
